ieee_out_conv: RTL and testbench



---
 rtl/mac_pkg.sv | 51 +++++
 rtl/ieee_out_fifo.sv | 50 +++++
 rtl/ieee_out_conv.sv | 137 +++++++++++++
 tb/tb_ieee_out_conv.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared MAC-unit types: FloPoCo/IEEE-754 widths, exception encodings,
// output-stage FSM states and the FloPoCo -> binary64 conversion.
package mac_pkg;

  localparam int FP_W   = 66;
  localparam int IEEE_W = 64;
  localparam int EXP_W  = 11;
  localparam int FRAC_W = 52;

  typedef enum logic [1:0] {
    EXN_ZERO   = 2'b00,
    EXN_NORMAL = 2'b01,
    EXN_INF    = 2'b10,
    EXN_NAN    = 2'b11
  } exn_e;

  typedef struct packed {
    exn_e              exn;
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } flopoco_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } out_state_e;

  localparam logic [IEEE_W-1:0] IEEE_QNAN = 64'h7FF8_0000_0000_0000;
  localparam logic [EXP_W-1:0]  EXP_MAX   = '1;

  // Same exponent bias on both sides; FloPoCo exp 0 and 2047 have no IEEE
  // normal equivalent, so they flush to zero and saturate to infinity.
  function automatic logic [IEEE_W-1:0] flopoco_to_ieee(input flopoco_t x);
    logic [IEEE_W-1:0] r;
    r = {x.sign, {(IEEE_W-1){1'b0}}};
    case (x.exn)
      EXN_NORMAL: begin
        if (x.exp == EXP_MAX)
          r = {x.sign, EXP_MAX, {FRAC_W{1'b0}}};
        else if (x.exp != '0)
          r = {x.sign, x.exp, x.frac};
      end
      EXN_INF: r = {x.sign, EXP_MAX, {FRAC_W{1'b0}}};
      EXN_NAN: r = IEEE_QNAN;
      default: r = {x.sign, {(IEEE_W-1){1'b0}}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ieee_out_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head word is valid
// whenever count_o != 0, writes when full are ignored unless a read frees a slot.
module ieee_out_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          rst_n_i,
  input  logic          wr_vld_i,
  input  logic [DW-1:0] wr_dat_i,
  input  logic          rd_rdy_i,
  output logic          rd_vld_o,
  output logic [DW-1:0] rd_dat_o,
  output logic [AW:0]   count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          wr_en, rd_en;

  assign rd_en = rd_rdy_i && (count_q != '0);
  assign wr_en = wr_vld_i && ((count_q != (AW+1)'(DEPTH)) || rd_en);

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  assign rd_vld_o = (count_q != '0);
  assign rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;
  assign count_o  = count_q;

endmodule

// File: rtl/ieee_out_conv.sv
// SpMV output stage: FloPoCo -> IEEE-754 conversion (2 stages) into a show-ahead
// FIFO; almost_full throttles upstream, eof_out fires once the matrix is fully popped.
module ieee_out_conv
  import mac_pkg::*;
#(
  parameter int FIFO_DEPTH      = 16,
  parameter int LOG2_FIFO_DEPTH = $clog2(FIFO_DEPTH),
  parameter int COUNT_WIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_in,
  input  logic [FP_W-1:0]        v_in,
  input  logic                   eof_in,
  output logic                   almost_full,
  output logic                   out_valid,
  output logic [IEEE_W-1:0]      v_out,
  input  logic                   pop,
  output logic                   eof_out,
  output logic [COUNT_WIDTH-1:0] result_count,
  output logic                   overflow
);

  localparam int OCC_W = LOG2_FIFO_DEPTH + 2;

  logic                   s1_vld_q, s2_vld_q, overflow_q;
  flopoco_t               s1_dat_q;
  logic [IEEE_W-1:0]      s2_dat_q;
  logic [LOG2_FIFO_DEPTH:0] fifo_cnt;
  logic [OCC_W-1:0]       occ;
  logic                   push_acc, pop_acc;

  out_state_e             state_q, state_d;
  logic [COUNT_WIDTH-1:0] push_cnt_q, push_cnt_d;
  logic [COUNT_WIDTH-1:0] pop_cnt_q, pop_cnt_d;
  logic [COUNT_WIDTH-1:0] tgt_q, tgt_d;
  logic [COUNT_WIDTH-1:0] res_cnt_q, res_cnt_d;
  logic                   eof_q, eof_d;

  // In-flight pipeline entries count against FIFO space so they can always land.
  assign occ         = OCC_W'(fifo_cnt) + OCC_W'(s1_vld_q) + OCC_W'(s2_vld_q);
  assign almost_full = (occ >= OCC_W'(FIFO_DEPTH - 1));
  assign push_acc    = push_in && !almost_full;
  assign pop_acc     = pop && out_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld_q   <= 1'b0;
      s1_dat_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_dat_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      s1_vld_q <= push_acc;
      if (push_acc) s1_dat_q <= flopoco_t'(v_in);
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) s2_dat_q <= flopoco_to_ieee(s1_dat_q);
      if (push_in && almost_full) overflow_q <= 1'b1;
    end
  end

  ieee_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (LOG2_FIFO_DEPTH),
    .DW    (IEEE_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n_i  (rst),
    .wr_vld_i (s2_vld_q),
    .wr_dat_i (s2_dat_q),
    .rd_rdy_i (pop),
    .rd_vld_o (out_valid),
    .rd_dat_o (v_out),
    .count_o  (fifo_cnt)
  );

  // The matrix is tagged by the push count at eof_in; drain ends when pops reach it.
  always_comb begin
    state_d    = state_q;
    push_cnt_d = push_cnt_q + COUNT_WIDTH'(push_acc);
    pop_cnt_d  = pop_cnt_q + COUNT_WIDTH'(pop_acc);
    tgt_d      = tgt_q;
    eof_d      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (eof_in) begin
          state_d    = ST_DRAIN;
          tgt_d      = push_cnt_q + COUNT_WIDTH'(push_acc);
          push_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (pop_cnt_q == tgt_q) begin
          state_d   = ST_RUN;
          eof_d     = 1'b1;
          pop_cnt_d = COUNT_WIDTH'(pop_acc);
        end else if (pop_cnt_d == tgt_q) begin
          state_d   = ST_RUN;
          eof_d     = 1'b1;
          pop_cnt_d = '0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    res_cnt_d = res_cnt_q;
    if (eof_q)
      res_cnt_d = COUNT_WIDTH'(pop_acc);
    else if (pop_acc && (res_cnt_q != '1))
      res_cnt_d = res_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      push_cnt_q <= '0;
      pop_cnt_q  <= '0;
      tgt_q      <= '0;
      res_cnt_q  <= '0;
      eof_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      push_cnt_q <= push_cnt_d;
      pop_cnt_q  <= pop_cnt_d;
      tgt_q      <= tgt_d;
      res_cnt_q  <= res_cnt_d;
      eof_q      <= eof_d;
    end
  end

  assign eof_out      = eof_q;
  assign result_count = res_cnt_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_ieee_out_conv.sv
// Directed bench for ieee_out_conv: conversion classes, backpressure,
// overflow, end-of-matrix tracking and mid-run reset.
module tb_ieee_out_conv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push_in = 1'b0;
  logic [65:0] v_in = '0;
  logic        eof_in = 1'b0;
  logic        pop = 1'b0;
  logic        almost_full, out_valid, eof_out, overflow;
  logic [63:0] v_out;
  logic [31:0] result_count;

  int n_vec = 0;
  int n_err = 0;

  ieee_out_conv #(
    .FIFO_DEPTH      (16),
    .LOG2_FIFO_DEPTH (4),
    .COUNT_WIDTH     (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push_in      (push_in),
    .v_in         (v_in),
    .eof_in       (eof_in),
    .almost_full  (almost_full),
    .out_valid    (out_valid),
    .v_out        (v_out),
    .pop          (pop),
    .eof_out      (eof_out),
    .result_count (result_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [65:0] fnorm(input logic [51:0] f);
    return {2'b01, 1'b0, 11'h3FF, f};
  endfunction

  function automatic logic [63:0] inorm(input logic [51:0] f);
    return {1'b0, 11'h3FF, f};
  endfunction

  task automatic push1(input logic [51:0] f);
    push_in = 1'b1;
    v_in    = fnorm(f);
    step();
    push_in = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [51:0] f);
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk(tag, v_out, inorm(f));
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; push_in = 1'b0; pop = 1'b0; eof_in = 1'b0;
    step();
    rst = 1'b1;
  endtask

  logic [65:0] cv_in  [6];
  logic [63:0] cv_exp [6];
  logic        seen;

  initial begin
    cv_in[0] = {2'b00, 1'b1, 11'h123, 52'h5};          cv_exp[0] = 64'h8000_0000_0000_0000;
    cv_in[1] = {2'b10, 1'b0, 11'h000, 52'h0};          cv_exp[1] = 64'h7FF0_0000_0000_0000;
    cv_in[2] = {2'b11, 1'b1, 11'h000, 52'h5};          cv_exp[2] = 64'h7FF8_0000_0000_0000;
    cv_in[3] = {2'b01, 1'b0, 11'h000, 52'h1};          cv_exp[3] = 64'h0000_0000_0000_0000;
    cv_in[4] = {2'b01, 1'b1, 11'h7FF, 52'h0};          cv_exp[4] = 64'hFFF0_0000_0000_0000;
    cv_in[5] = {2'b01, 1'b1, 11'h400, 52'h8_0000_0000_0000}; cv_exp[5] = 64'hC008_0000_0000_0000;

    // Reset state
    step(); step();
    rst = 1'b1;
    chk("rst_af",   64'(almost_full),  64'd0);
    chk("rst_ov",   64'(out_valid),    64'd0);
    chk("rst_vout", v_out,             64'd0);
    chk("rst_eof",  64'(eof_out),      64'd0);
    chk("rst_cnt",  64'(result_count), 64'd0);
    chk("rst_ovf",  64'(overflow),     64'd0);

    // Single 1.0: visible exactly three cycles after the push
    push_in = 1'b1; v_in = {2'b01, 1'b0, 11'h3FF, 52'h0};
    step();
    push_in = 1'b0;
    chk("lat_t1", 64'(out_valid), 64'd0);
    step();
    chk("lat_t2", 64'(out_valid), 64'd0);
    step();
    chk("lat_t3", 64'(out_valid), 64'd1);
    chk("one", v_out, 64'h3FF0_0000_0000_0000);
    pop = 1'b1; step(); pop = 1'b0;
    chk("one_gone", 64'(out_valid), 64'd0);

    // Exception classes, back-to-back
    for (int i = 0; i < 6; i++) begin
      push_in = 1'b1; v_in = cv_in[i];
      step();
    end
    push_in = 1'b0;
    step(); step();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("exc%0d_vld", i), 64'(out_valid), 64'd1);
      chk($sformatf("exc%0d", i), v_out, cv_exp[i]);
      pop = 1'b1; step(); pop = 1'b0;
    end

    // Backpressure: 15 accepted pushes raise almost_full
    for (int i = 1; i <= 15; i++) begin
      chk($sformatf("bp_af_lo%0d", i), 64'(almost_full), 64'd0);
      push1(52'(i));
    end
    chk("bp_af_hi", 64'(almost_full), 64'd1);
    step(); step(); step();
    chk("bp_af_hold", 64'(almost_full), 64'd1);
    chk("bp_ovf", 64'(overflow), 64'd0);
    for (int i = 1; i <= 15; i++) begin
      if (i == 2) chk("bp_af_fall", 64'(almost_full), 64'd0);
      pop_chk($sformatf("bp%0d", i), 52'(i));
    end
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Overflow: push while almost_full is dropped and flagged
    for (int i = 1; i <= 15; i++) push1(52'h20 + 52'(i));
    chk("of_af", 64'(almost_full), 64'd1);
    push1(52'hBAD);
    chk("of_set", 64'(overflow), 64'd1);
    step(); step(); step();
    for (int i = 1; i <= 15; i++) pop_chk($sformatf("of%0d", i), 52'h20 + 52'(i));
    chk("of_nodrop", 64'(out_valid), 64'd0);
    chk("of_sticky", 64'(overflow), 64'd1);

    // EOF with nothing pushed: eof_out two cycles later
    do_reset();
    eof_in = 1'b1; step(); eof_in = 1'b0;
    chk("eof0_t1", 64'(eof_out), 64'd0);
    step();
    chk("eof0_t2", 64'(eof_out), 64'd1);
    chk("eof0_cnt", 64'(result_count), 64'd0);
    step();
    chk("eof0_t3", 64'(eof_out), 64'd0);

    // EOF on 5th push, 6th push lands during drain
    for (int i = 1; i <= 4; i++) push1(52'h50 + 52'(i));
    push_in = 1'b1; eof_in = 1'b1; v_in = fnorm(52'h55);
    step();
    push_in = 1'b0; eof_in = 1'b0;
    push1(52'h56);
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("eof_idle%0d", i), 64'(eof_out), 64'd0);
      step();
      chk($sformatf("eof_cnt%0d", i), 64'(result_count), 64'(i - 1));
      pop_chk($sformatf("eof_pop%0d", i), 52'h50 + 52'(i));
    end
    chk("eof_pulse", 64'(eof_out), 64'd1);
    chk("eof_cnt5", 64'(result_count), 64'd5);
    step();
    chk("eof_end", 64'(eof_out), 64'd0);
    chk("eof_clr", 64'(result_count), 64'd0);
    pop_chk("eof_next", 52'h56);
    chk("eof_next_cnt", 64'(result_count), 64'd1);

    // Reset mid-drain discards everything, no eof_out afterward
    for (int i = 1; i <= 7; i++) push1(52'h70 + 52'(i));
    push_in = 1'b1; eof_in = 1'b1; v_in = fnorm(52'h78);
    step();
    push_in = 1'b0; eof_in = 1'b0;
    step(); step(); step();
    chk("mr_pre_vld", 64'(out_valid), 64'd1);
    do_reset();
    chk("mr_ov",   64'(out_valid),    64'd0);
    chk("mr_af",   64'(almost_full),  64'd0);
    chk("mr_cnt",  64'(result_count), 64'd0);
    chk("mr_vout", v_out,             64'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen = seen | eof_out;
      step();
    end
    chk("mr_no_eof", 64'(seen), 64'd0);
    chk("mr_still_empty", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
